// File: rtl/multiplier_seq_pkg.sv
// Shared types for the iterative multiplier: FSM state encoding and default iteration count.
// Imported by multiplier_seq; holds no logic.
package multiplier_seq_pkg;

  localparam int MUL_WIDTH = 64;
  localparam int MUL_DELAY = MUL_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/multiplier_seq.sv
// Radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, per-operand signedness; done MUL_DELAY+2 cycles after accept.
// valid is level-held by the issuer; dropping it in any state aborts back to IDLE with done/c cleared.
module multiplier_seq #(
  parameter int WIDTH     = 64,
  parameter int MUL_DELAY = WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid,
  input  logic               a_signed,
  input  logic               b_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);
  import multiplier_seq_pkg::*;

  localparam int CW = $clog2(MUL_DELAY + 1);

  mul_state_e         state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   p;
  logic               neg;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     acc;
  logic [2*WIDTH:0]   p_next;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    a_neg  = a_signed & a[WIDTH-1];
    b_neg  = b_signed & b[WIDTH-1];
    a_abs  = a_neg ? -a : a;
    b_abs  = b_neg ? -b : b;
    // Upper half is at most 2^W-1 before the add, so the W+1-bit sum never overflows.
    acc    = p[2*WIDTH:WIDTH] + (p[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    p_next = {1'b0, acc, p[WIDTH-1:1]};
    prod   = p[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      count <= '0;
      mcand <= '0;
      p     <= '0;
      neg   <= 1'b0;
      done  <= 1'b0;
      c     <= '0;
    end else if (!valid) begin
      // Abort wins over every transition, including FIX -> DONE.
      state <= IDLE;
      count <= '0;
      mcand <= '0;
      p     <= '0;
      neg   <= 1'b0;
      done  <= 1'b0;
      c     <= '0;
    end else begin
      case (state)
        IDLE: begin
          mcand <= a_abs;
          p     <= {{(WIDTH+1){1'b0}}, b_abs};
          neg   <= a_neg ^ b_neg;
          count <= CW'(MUL_DELAY);
          state <= BUSY;
        end
        BUSY: begin
          p     <= p_next;
          count <= count - CW'(1);
          if (count == CW'(1))
            state <= FIX;
        end
        FIX: begin
          c     <= neg ? -prod : prod;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          c     <= '0;
        end
      endcase
    end
  end

endmodule
